// File: rtl/button_pulse_conditioner.sv
// Synchronises and debounces raw push-button levels, then emits one-cycle one-hot
// press pulses (highest index wins on a tie) plus a collision flag and debounced levels.
module button_pulse_conditioner #(
   parameter int N_B             = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_BITS        = 20
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N_B-1:0] i_buttons_raw,
   output logic [N_B-1:0] o_buttons,
   output logic [N_B-1:0] o_level,
   output logic           o_collision
);

   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic [N_B-1:0]      r_sync_p0;
   logic [N_B-1:0]      r_sync_p1;
   logic [N_B-1:0]      r_db_p2;
   logic [N_B-1:0]      r_ev_p3;
   logic [CNT_BITS-1:0] r_cnt_p2 [N_B];

   logic [N_B-1:0]      w_db_next;
   logic [CNT_BITS-1:0] w_cnt_next [N_B];

   function automatic logic [N_B-1:0] highest_bit(input logic [N_B-1:0] v);
      logic [N_B-1:0] h;
      h = '0;
      for (int i = 0; i < N_B; i++) begin
         if (v[i]) begin
            h    = '0;
            h[i] = 1'b1;
         end
      end
      return h;
   endfunction

   function automatic logic multi_hot(input logic [N_B-1:0] v);
      return (v & (v - N_B'(1))) != '0;
   endfunction

   // Per-bit debounce: any return of the synchronised level to db restarts the count.
   always_comb begin
      for (int i = 0; i < N_B; i++) begin
         w_db_next[i]  = r_db_p2[i];
         w_cnt_next[i] = r_cnt_p2[i];
         if (r_sync_p1[i] == r_db_p2[i]) begin
            w_cnt_next[i] = '0;
         end else if (r_cnt_p2[i] == CNT_LAST) begin
            w_db_next[i]  = r_sync_p1[i];
            w_cnt_next[i] = '0;
         end else begin
            w_cnt_next[i] = r_cnt_p2[i] + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync_p0   <= '0;
         r_sync_p1   <= '0;
         r_db_p2     <= '0;
         r_ev_p3     <= '0;
         o_buttons   <= '0;
         o_collision <= 1'b0;
         for (int i = 0; i < N_B; i++) r_cnt_p2[i] <= '0;
      end else begin
         // stage p0/p1: two-flop synchroniser
         r_sync_p0 <= i_buttons_raw;
         r_sync_p1 <= r_sync_p0;
         // stage p2: debounced level and counters
         r_db_p2   <= w_db_next;
         for (int i = 0; i < N_B; i++) r_cnt_p2[i] <= w_cnt_next[i];
         // stage p3: rising-edge press events
         r_ev_p3   <= w_db_next & ~r_db_p2;
         // stage p4: arbitrated one-hot pulse and collision flag
         o_buttons   <= highest_bit(r_ev_p3);
         o_collision <= multi_hot(r_ev_p3);
      end
   end

   assign o_level = r_db_p2;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with DEBOUNCE_CYCLES=4, N_B=3.
module tb_button_pulse_conditioner;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw   = 3'b000;
   logic [2:0] o_buttons;
   logic [2:0] o_level;
   logic       o_collision;

   int checks   = 0;
   int failures = 0;

   button_pulse_conditioner #(
      .N_B(3),
      .DEBOUNCE_CYCLES(4),
      .CNT_BITS(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .i_buttons_raw(raw),
      .o_buttons(o_buttons),
      .o_level(o_level),
      .o_collision(o_collision)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      raw = 3'b000;
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic test_reset();
      raw   = 3'b111;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (o_buttons !== 3'b000) begin
         failures++;
         $display("FAIL reset_buttons got=%b want=000", o_buttons);
      end
      checks++;
      if (o_level !== 3'b000) begin
         failures++;
         $display("FAIL reset_level got=%b want=000", o_level);
      end
      checks++;
      if (o_collision !== 1'b0) begin
         failures++;
         $display("FAIL reset_collision got=%b want=0", o_collision);
      end
      raw   = 3'b000;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) tick();
   endtask

   task automatic test_clean_press();
      logic [2:0] eb, el;
      raw = 3'b100;
      for (int k = 0; k < 20; k++) begin
         tick();
         eb = (k == 6) ? 3'b100 : 3'b000;
         el = (k >= 5) ? 3'b100 : 3'b000;
         checks++;
         if (o_buttons !== eb) begin
            failures++;
            $display("FAIL clean_press_buttons k=%0d got=%b want=%b", k, o_buttons, eb);
         end
         checks++;
         if (o_level !== el) begin
            failures++;
            $display("FAIL clean_press_level k=%0d got=%b want=%b", k, o_level, el);
         end
         checks++;
         if (o_collision !== 1'b0) begin
            failures++;
            $display("FAIL clean_press_collision k=%0d got=%b want=0", k, o_collision);
         end
      end
   endtask

   task automatic test_release();
      logic [2:0] eb, el;
      raw = 3'b000;
      for (int k = 0; k < 12; k++) begin
         tick();
         el = (k < 5) ? 3'b100 : 3'b000;
         checks++;
         if (o_level !== el) begin
            failures++;
            $display("FAIL release_level k=%0d got=%b want=%b", k, o_level, el);
         end
         checks++;
         if (o_buttons !== 3'b000) begin
            failures++;
            $display("FAIL release_buttons k=%0d got=%b want=000", k, o_buttons);
         end
      end
      raw = 3'b100;
      for (int k = 0; k < 10; k++) begin
         tick();
         eb = (k == 6) ? 3'b100 : 3'b000;
         checks++;
         if (o_buttons !== eb) begin
            failures++;
            $display("FAIL repress_buttons k=%0d got=%b want=%b", k, o_buttons, eb);
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      logic [2:0] eb, el;
      for (int k = 0; k < 8; k++) begin
         raw = (k % 2 == 0) ? 3'b010 : 3'b000;
         tick();
         checks++;
         if (o_buttons !== 3'b000 || o_level !== 3'b000) begin
            failures++;
            $display("FAIL bounce_quiet k=%0d got buttons=%b level=%b want 000/000", k, o_buttons, o_level);
         end
      end
      raw = 3'b010;
      for (int k = 0; k < 14; k++) begin
         tick();
         eb = (k == 6) ? 3'b010 : 3'b000;
         el = (k >= 5) ? 3'b010 : 3'b000;
         checks++;
         if (o_buttons !== eb) begin
            failures++;
            $display("FAIL bounce_buttons k=%0d got=%b want=%b", k, o_buttons, eb);
         end
         checks++;
         if (o_level !== el) begin
            failures++;
            $display("FAIL bounce_level k=%0d got=%b want=%b", k, o_level, el);
         end
      end
      settle();
   endtask

   task automatic test_glitch();
      raw = 3'b001;
      for (int k = 0; k < 15; k++) begin
         if (k == 3) raw = 3'b000;
         tick();
         checks++;
         if (o_buttons !== 3'b000 || o_level !== 3'b000) begin
            failures++;
            $display("FAIL glitch k=%0d got buttons=%b level=%b want 000/000", k, o_buttons, o_level);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] eb, el;
      logic       ec;
      raw = 3'b011;
      for (int k = 0; k < 14; k++) begin
         tick();
         eb = (k == 6) ? 3'b010 : 3'b000;
         ec = (k == 6);
         el = (k >= 5) ? 3'b011 : 3'b000;
         checks++;
         if (o_buttons !== eb) begin
            failures++;
            $display("FAIL simul_buttons k=%0d got=%b want=%b", k, o_buttons, eb);
         end
         checks++;
         if (o_collision !== ec) begin
            failures++;
            $display("FAIL simul_collision k=%0d got=%b want=%b", k, o_collision, ec);
         end
         checks++;
         if (o_level !== el) begin
            failures++;
            $display("FAIL simul_level k=%0d got=%b want=%b", k, o_level, el);
         end
      end
      settle();
   endtask

   task automatic test_reset_mid();
      logic [2:0] eb, el;
      raw = 3'b001;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (o_buttons !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_pre k=%0d got=%b want=000", k, o_buttons);
         end
      end
      reset = 1'b1;
      tick();
      checks++;
      if (o_buttons !== 3'b000 || o_level !== 3'b000 || o_collision !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_during got buttons=%b level=%b coll=%b want 000/000/0",
                  o_buttons, o_level, o_collision);
      end
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         eb = (k == 6) ? 3'b001 : 3'b000;
         el = (k >= 5) ? 3'b001 : 3'b000;
         checks++;
         if (o_buttons !== eb) begin
            failures++;
            $display("FAIL rstmid_buttons k=%0d got=%b want=%b", k, o_buttons, eb);
         end
         checks++;
         if (o_level !== el) begin
            failures++;
            $display("FAIL rstmid_level k=%0d got=%b want=%b", k, o_level, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
- Upstream stage for the operand/opcode register bank.
- Takes raw, bouncing, asynchronous push-button levels and synchronises and debounces them.
- Emits clean single-cycle one-hot press pulses. The downstream bank decodes these as exact one-hot patterns (MSB = load A, middle = load B, LSB = load OP).
- Also exports the debounced levels and a collision flag for simultaneous presses.

Parameters:
- N_B, 3, number of buttons (bit i of input maps to bit i of output).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz). Must be >= 2.
- CNT_BITS, 20, width of each debounce counter. Must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_buttons_raw  input  N_B  raw asynchronous button levels, 1 = pressed.
- o_buttons  output  N_B  one-cycle one-hot press pulse; all-zero otherwise.
- o_level  output  N_B  debounced button levels.
- o_collision  output  1  one-cycle flag: more than one press event in the same cycle.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset). Every register is cleared on the edge where reset=1; no asynchronous paths.
- Reset values: o_buttons=0, o_level=0, o_collision=0. Synchroniser flops, counters and press-event registers also 0.
- Synchroniser: per bit, two flops s1 <= raw, s2 <= s1. Only s2 is used downstream of the synchroniser.
- Debounce, per bit, with registers cnt and db (db drives o_level):
  - s2 == db: cnt <= 0.
  - s2 != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Any return of s2 to db before the count completes restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES cycles never change db.
- Press event: ev[i] = db[i] rises 0->1 on this edge (combinational from db next/current, or registered; either way the output latency below is fixed). Release (1->0) updates o_level only; no pulse.
- Output register: o_buttons and o_collision are registered and high for exactly one cycle per event.
  - Exactly one ev bit set: o_buttons = that bit, o_collision = 0.
  - More than one ev bit set: o_buttons = highest-index ev bit only, o_collision = 1, lower events dropped.
  - No ev bit set: o_buttons = 0, o_collision = 0.
- One-hot guarantee: o_buttons never has more than one bit set.
- Latency: raw held high, first sampled by s1 at edge t.
  - db rises at edge t+DEBOUNCE_CYCLES+1.
  - o_buttons bit high after edge t+DEBOUNCE_CYCLES+2, cleared after the next edge.
- Holding a button: exactly one pulse per press regardless of hold time. A new pulse requires a debounced release followed by a debounced press.
- Reset mid-operation: counters and db are cleared; a debounce in progress is discarded; any pulse scheduled for the reset cycle is suppressed.
- Button held through reset: after reset deasserts it is re-debounced from db=0 and produces one pulse DEBOUNCE_CYCLES+2 edges after reset release. This is intentional.
- Buttons are independent: debounce counters of different bits never interact; only the output arbitration couples them.

Test Plan (DEBOUNCE_CYCLES=4, N_B=3):
- Clean press: raw=3'b100 held 20 cycles from edge t -> o_buttons=3'b100 only in the cycle after edge t+6; o_level[2]=1 from t+5; no further pulses while held.
- Bounce rejection: raw[1] toggles 1,0,1,0 every cycle for 8 cycles, then holds 1 -> no pulse during bounce; exactly one o_buttons=3'b010 pulse 6 edges after the final stable rise is sampled.
- Short glitch: raw[0]=1 for 3 cycles, then 0 -> o_buttons stays 0, o_level stays 0.
- Simultaneous press: raw 3'b000 -> 3'b011 on one edge, held -> single o_buttons=3'b010 pulse with o_collision=1 in the same cycle; bit 0 event dropped.
- Release: after the clean press, raw=0 held -> o_level[2] falls 5 edges after sampling; no o_buttons pulse. A second press then yields a new 3'b100 pulse.
- Reset mid-debounce: raw=3'b001 held, reset asserted 1 cycle at edge t+3, raw still held -> no pulse before reset; one 3'b001 pulse 6 edges after the first post-reset edge; all outputs 0 during the reset cycle.
